// File: rtl/spi_master_multi_if.sv
// Control-side bundle for spi_master_multi: request/response plus the SPI pins.
// The DUT takes the master modport; the controlling logic (or a bench) takes the slave modport.
interface spi_master_multi_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 5,
    parameter int NUM_CS     = 4,
    parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [LEN_WIDTH-1:0]  data_length_in;
    logic [CS_W-1:0]       cs_select_in;
    logic                  cpol_in;
    logic                  cpha_in;
    logic                  start_in;
    logic                  busy_out;
    logic                  done_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  sclk_out;
    logic                  mosi_out;
    logic                  miso_in;
    logic [NUM_CS-1:0]     cs_out;

    modport master (
        input  data_in, data_length_in, cs_select_in, cpol_in, cpha_in, start_in, miso_in,
        output busy_out, done_out, data_out, sclk_out, mosi_out, cs_out
    );

    modport slave (
        output data_in, data_length_in, cs_select_in, cpol_in, cpha_in, start_in, miso_in,
        input  busy_out, done_out, data_out, sclk_out, mosi_out, cs_out
    );
endinterface

// File: rtl/spi_master_multi.sv
// Multi-mode SPI master: CPOL/CPHA, NUM_CS selects, 1..DATA_WIDTH bit frames, CS setup/hold.
// Define SPI_RX_EN to build the MISO capture path; otherwise data_out is tied to zero.
module spi_master_multi #(
    parameter int DATA_WIDTH      = 16,
    parameter int LEN_WIDTH       = 5,
    parameter int NUM_CS          = 4,
    parameter int SCLK_PRESCALER  = 100,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2
) (
    input  logic               clock_in,
    input  logic               reset_in,
    spi_master_multi_if.master bus
);
    localparam int H     = SCLK_PRESCALER / 2;
    localparam int CMAX  = (SCLK_PRESCALER > CS_SETUP_CYCLES)
                         ? ((SCLK_PRESCALER > CS_HOLD_CYCLES) ? SCLK_PRESCALER : CS_HOLD_CYCLES)
                         : ((CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES);
    localparam int CNT_W = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [LEN_WIDTH-1:0]  r_bit;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [DATA_WIDTH-1:0] r_sh;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [NUM_CS-1:0]     r_cs;

    logic                  w_len_ok;
    logic                  w_accept;
    logic                  w_last_bit;
    logic                  w_trail;
    logic                  w_done_nxt;
    logic [DATA_WIDTH-1:0] w_aligned;

    assign w_len_ok   = (bus.data_length_in != '0) &&
                        (bus.data_length_in <= LEN_WIDTH'(DATA_WIDTH));
    assign w_accept   = (r_state == ST_IDLE) && bus.start_in && w_len_ok;
    // Left-align the frame so the next tx bit is always the shift register MSB.
    assign w_aligned  = bus.data_in << (LEN_WIDTH'(DATA_WIDTH) - bus.data_length_in);
    assign w_last_bit = (r_bit == r_len - LEN_WIDTH'(1));
    assign w_trail    = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(H - 1));
    assign w_done_nxt = (r_state == ST_HOLD) && (r_cnt == CNT_W'(CS_HOLD_CYCLES - 1));

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_len   <= '0;
            r_sh    <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs    <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_cs    <= ~(NUM_CS'(1) << bus.cs_select_in);
                        r_sclk  <= bus.cpol_in;
                        r_cpol  <= bus.cpol_in;
                        r_cpha  <= bus.cpha_in;
                        r_len   <= bus.data_length_in;
                        r_sh    <= w_aligned;
                        r_mosi  <= bus.cpha_in ? 1'b0 : w_aligned[DATA_WIDTH-1];
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == CNT_W'(CS_SETUP_CYCLES - 1)) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= ~r_cpol;
                        if (r_cpha) begin
                            r_mosi <= r_sh[DATA_WIDTH-1];
                            r_sh   <= r_sh << 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == CNT_W'(SCLK_PRESCALER - 1)) begin
                        r_cnt <= '0;
                        if (w_last_bit) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_bit  <= r_bit + LEN_WIDTH'(1);
                            r_sclk <= ~r_cpol;
                            if (r_cpha) begin
                                r_mosi <= r_sh[DATA_WIDTH-1];
                                r_sh   <= r_sh << 1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    // Mode-0/2 MOSI moves on the trailing edge but freezes after the final bit.
                    if (w_trail) begin
                        r_sclk <= r_cpol;
                        if (!r_cpha && !w_last_bit) begin
                            r_mosi <= r_sh[DATA_WIDTH-2];
                            r_sh   <= r_sh << 1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_done_nxt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cs    <= '1;
                        r_mosi  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_RX_EN
    logic                  w_lead;
    logic                  w_sample;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_data;

    assign w_lead   = ((r_state == ST_SETUP) && (r_cnt == CNT_W'(CS_SETUP_CYCLES - 1))) ||
                      ((r_state == ST_SHIFT) && (r_cnt == CNT_W'(SCLK_PRESCALER - 1)) && !w_last_bit);
    assign w_sample = r_cpha ? w_trail : w_lead;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_rx   <= '0;
            r_data <= '0;
        end else begin
            if (w_accept)
                r_rx <= '0;
            else if (w_sample)
                r_rx <= {r_rx[DATA_WIDTH-2:0], bus.miso_in};
            if (w_done_nxt)
                r_data <= r_rx;
        end
    end

    assign bus.data_out = r_data;
`else
    assign bus.data_out = '0;
`endif

    assign bus.busy_out = r_busy;
    assign bus.done_out = r_done;
    assign bus.sclk_out = r_sclk;
    assign bus.mosi_out = r_mosi;
    assign bus.cs_out   = r_cs;
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a frame-level reference model checked every cycle.
module tb_spi_master_multi;
    localparam int DW = 16, LW = 5, NCS = 4, P = 4, H = 2, S = 2, HD = 2;
`ifdef SPI_RX_EN
    localparam bit RX = 1'b1;
`else
    localparam bit RX = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_multi_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .NUM_CS(NCS)) bus ();

    spi_master_multi #(
        .DATA_WIDTH(DW), .LEN_WIDTH(LW), .NUM_CS(NCS),
        .SCLK_PRESCALER(P), .CS_SETUP_CYCLES(S), .CS_HOLD_CYCLES(HD)
    ) dut (
        .clock_in(clk),
        .reset_in(rst),
        .bus(bus)
    );

    int n_err = 0, n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // far-end word and loopback select
    logic [DW-1:0] rx_word = '0;
    logic          loop_en = 1'b0;
    logic          miso_s  = 1'b0;
    assign bus.miso_in = loop_en ? bus.mosi_out : miso_s;

    // ---------------- reference model: frame phase counter ----------------
    int            m_k = 0, m_T = 0, m_len = 1, m_sel = 0;
    logic [DW-1:0] m_data = '0, m_rxw = '0, exp_dout = '0;
    logic          m_cpol = 1'b0, m_cpha = 1'b0, idle_cpol = 1'b0;
    bit            pre_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_k = 0; idle_cpol = 1'b0; exp_dout = '0;
        end else begin
            pre_busy = (m_k >= 1 && m_k <= m_T);
            if (bus.start_in && !pre_busy && bus.data_length_in >= 1 && bus.data_length_in <= DW) begin
                m_k = 1;
                m_len = int'(bus.data_length_in);
                m_T = S + m_len * P + HD;
                m_data = bus.data_in;
                m_sel = int'(bus.cs_select_in);
                m_cpol = bus.cpol_in; m_cpha = bus.cpha_in; idle_cpol = bus.cpol_in;
                m_rxw = rx_word & DW'((32'd1 << m_len) - 1);
            end else if (pre_busy) begin
                m_k++;
                if (m_k == m_T + 1) exp_dout = RX ? m_rxw : '0;
            end else begin
                m_k = 0;
            end
        end
    end

    function automatic logic tbit(input int b);
        return m_data[m_len - 1 - b];
    endfunction

    // ---------------- per-cycle compare ----------------
    logic           e_busy, e_done, e_sclk, e_mosi, mosi_care;
    logic [NCS-1:0] e_cs, one_cs;
    int             t, u, b, c, bb;
    always begin
        @(posedge clk); #1;
        one_cs = NCS'(1);
        mosi_care = 1'b1;
        if (m_k >= 1 && m_k <= m_T) begin
            t = m_k - 1;
            e_busy = 1'b1; e_done = 1'b0; e_cs = ~(one_cs << m_sel);
            if (t < S) begin
                e_sclk = m_cpol;
                e_mosi = tbit(0);
                mosi_care = !m_cpha;
            end else if (t < S + m_len * P) begin
                u = t - S; b = u / P; c = u % P;
                e_sclk = (c < H) ? ~m_cpol : m_cpol;
                if (m_cpha) bb = b;
                else        bb = (c < H) ? b : ((b + 1 < m_len) ? b + 1 : b);
                e_mosi = tbit(bb);
            end else begin
                e_sclk = m_cpol;
                e_mosi = tbit(m_len - 1);
            end
        end else begin
            e_busy = 1'b0; e_cs = '1; e_mosi = 1'b0; e_sclk = idle_cpol;
            e_done = (m_k == m_T + 1) && (m_k != 0);
        end
        chk("busy_out", bus.busy_out, e_busy);
        chk("done_out", bus.done_out, e_done);
        chk("cs_out", bus.cs_out, e_cs);
        chk("sclk_out", bus.sclk_out, e_sclk);
        if (mosi_care) chk("mosi_out", bus.mosi_out, e_mosi);
        chk("data_out", bus.data_out, exp_dout);
    end

    // ---------------- monitor + far-end slave (mode 0/2 shifting) ----------------
    int            busy_cnt = 0, done_cnt = 0, rise_cnt = 0, s_idx = 0, t_len = 1;
    logic [DW-1:0] mosi_cap = '0;
    logic          t_cpol = 1'b0, t_cpha = 1'b0, p_busy = 1'b0, p_sclk = 1'b0, lead;
    always begin
        @(posedge clk); #1;
        busy_cnt += int'(bus.busy_out);
        done_cnt += int'(bus.done_out);
        if (bus.busy_out && p_busy && bus.sclk_out != p_sclk) begin
            if (bus.sclk_out) rise_cnt++;
            lead = (bus.sclk_out != t_cpol);
            if (lead ^ t_cpha) mosi_cap = {mosi_cap[DW-2:0], bus.mosi_out};
            if (!lead && !t_cpha) s_idx++;
        end
        if (bus.cs_out == '1) s_idx = 0;
        miso_s = (s_idx < t_len && t_len <= DW) ? rx_word[t_len - 1 - s_idx] : 1'b0;
        p_busy = bus.busy_out;
        p_sclk = bus.sclk_out;
    end

    task automatic clr();
        busy_cnt = 0; done_cnt = 0; rise_cnt = 0; mosi_cap = '0;
    endtask

    task automatic start_frame(input logic [DW-1:0] d, input int len, input int sel,
                               input logic cpol, input logic cpha);
        @(negedge clk);
        bus.data_in = d; bus.data_length_in = LW'(len); bus.cs_select_in = 2'(sel);
        bus.cpol_in = cpol; bus.cpha_in = cpha; bus.start_in = 1'b1;
        t_len = len; t_cpol = cpol; t_cpha = cpha;
        @(negedge clk);
        bus.start_in = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (bus.done_out) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: done_out not seen within %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in = '0; bus.data_length_in = '0; bus.cs_select_in = '0;
        bus.cpol_in = 1'b0; bus.cpha_in = 1'b0; bus.start_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset cs_out", bus.cs_out, 4'hF);
        chk("reset busy_out", bus.busy_out, 0);
        chk("reset sclk_out", bus.sclk_out, 0);
        chk("reset data_out", bus.data_out, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: mode 0, 0xA5C3, cs 2
        clr();
        start_frame(16'hA5C3, 16, 2, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("t1 cs_out", bus.cs_out, 4'b1011);
        wait_done(100, "t1 done");
        @(negedge clk);
        chk("t1 busy cycles", busy_cnt, 68);
        chk("t1 done pulses", done_cnt, 1);
        chk("t1 mosi bits", mosi_cap, 16'hA5C3);

        // 2: mode 3 loopback, 8 bits
        loop_en = 1'b1; rx_word = 16'h00A5; clr();
        start_frame(16'h00A5, 8, 1, 1'b1, 1'b1);
        wait_done(60, "t2 done");
        chk("t2 data_out", bus.data_out, RX ? 16'h00A5 : 16'h0000);
        @(negedge clk);
        chk("t2 rising edges", rise_cnt, 8);
        chk("t2 sclk idle", bus.sclk_out, 1);
        chk("t2 mosi bits", mosi_cap[7:0], 8'hA5);
        loop_en = 1'b0;

        // 3: mode 2, slave returns 0x3C
        rx_word = 16'h003C; clr();
        start_frame(16'h0081, 8, 0, 1'b1, 1'b0);
        wait_done(60, "t3 done");
        chk("t3 data_out", bus.data_out, RX ? 16'h003C : 16'h0000);
        chk("t3 mosi bits", mosi_cap[7:0], 8'h81);
        @(negedge clk);

        // 4: start held -> back-to-back; mid-frame start ignored
        rx_word = '0; clr();
        bus.data_in = 16'h0009; bus.data_length_in = LW'(4); bus.cs_select_in = 2'd3;
        bus.cpol_in = 1'b0; bus.cpha_in = 1'b1; bus.start_in = 1'b1;
        t_len = 4; t_cpol = 1'b0; t_cpha = 1'b1;
        wait_done(40, "t4 first done");
        @(posedge clk); #1;
        chk("t4 back-to-back busy", bus.busy_out, 1);
        @(negedge clk); bus.start_in = 1'b0;
        repeat (5) @(negedge clk);
        bus.data_in = 16'hFFFF; bus.start_in = 1'b1;
        @(negedge clk); bus.start_in = 1'b0;
        wait_done(40, "t4 second done");
        @(negedge clk);
        chk("t4 done pulses", done_cnt, 2);
        chk("t4 busy cycles", busy_cnt, 40);

        // 5: reset after 10 bits of a 16-bit mode-2 frame
        rx_word = 16'hFFFF; clr();
        start_frame(16'hBEEF, 16, 0, 1'b1, 1'b0);
        repeat (41) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5 cs_out", bus.cs_out, 4'hF);
        chk("t5 busy_out", bus.busy_out, 0);
        chk("t5 sclk_out", bus.sclk_out, 0);
        chk("t5 done_out", bus.done_out, 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5 done pulses", done_cnt, 0);
        chk("t5 data_out", bus.data_out, 0);

        // 6: illegal lengths, then full 0xFFFF frame
        clr();
        start_frame(16'h1234, 0, 1, 1'b0, 1'b0);
        start_frame(16'h1234, 17, 1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("t6 bad len busy", busy_cnt, 0);
        chk("t6 bad len done", done_cnt, 0);
        rx_word = 16'hFFFF;
        start_frame(16'hFFFF, 16, 1, 1'b0, 1'b0);
        wait_done(100, "t6 done");
        chk("t6 data_out", bus.data_out, RX ? 16'hFFFF : 16'h0000);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
